// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch front-panel controller.
// Status encoding must match stopwatch_top.
package stopwatch_pkg;

   localparam logic [1:0] SW_IDLE    = 2'b00;
   localparam logic [1:0] SW_RUNNING = 2'b01;
   localparam logic [1:0] SW_PAUSED  = 2'b10;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StRunning = 2'd1,
      StPaused  = 2'd2,
      StWaitAck = 2'd3
   } ctrl_state_t;

   typedef struct packed {
      logic [7:0] minutes;
      logic [5:0] seconds;
   } lap_t;

   // Unused status code 11 falls back to idle.
   function automatic ctrl_state_t status_to_state(input logic [1:0] status);
      case (status)
         SW_IDLE:    return StIdle;
         SW_RUNNING: return StRunning;
         SW_PAUSED:  return StPaused;
         default:    return StIdle;
      endcase
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter, and a registered
// one-cycle pulse on each rising edge of the debounced level.
module btn_debounce #(
   parameter int unsigned DebounceCycles = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic rise_o
);

   localparam int unsigned CntW = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;

   logic            sync1_q, sync2_q;
   logic            level_q, level_d;
   logic            rise_q, rise_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   // Count resets to zero on any cycle the synchronised input agrees with the level.
   always_comb begin
      level_d = level_q;
      rise_d  = 1'b0;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CntW'(DebounceCycles - 1)) begin
            level_d = ~level_q;
            rise_d  = ~level_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         rise_q  <= rise_d;
         cnt_q   <= cnt_d;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Front-panel controller: debounced buttons drive start/stop/reset commands to the
// stopwatch, wait for status acknowledge, and queue lap times in a small FIFO.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned LAP_DEPTH       = 4,
   parameter int unsigned ACK_TIMEOUT     = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           btn_ss,
   input  logic                           btn_lr,
   input  logic [7:0]                     sw_minutes,
   input  logic [5:0]                     sw_seconds,
   input  logic [1:0]                     sw_status,
   output logic                           sw_start,
   output logic                           sw_stop,
   output logic                           sw_reset,
   output logic                           lap_valid,
   input  logic                           lap_ready,
   output logic [7:0]                     lap_minutes,
   output logic [5:0]                     lap_seconds,
   output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count,
   output logic                           lap_overflow,
   output logic                           ctrl_err,
   output logic [1:0]                     ctrl_state
);

   localparam int unsigned PtrW = $clog2(LAP_DEPTH);
   localparam int unsigned CntW = $clog2(LAP_DEPTH + 1);
   localparam int unsigned TmoW = $clog2(ACK_TIMEOUT + 1);

   logic ss_ev, lr_ev;

   btn_debounce #(
      .DebounceCycles(DEBOUNCE_CYCLES)
   ) u_db_ss (
      .clk_i (clk),
      .rst_ni(rst_n),
      .btn_i (btn_ss),
      .rise_o(ss_ev)
   );

   btn_debounce #(
      .DebounceCycles(DEBOUNCE_CYCLES)
   ) u_db_lr (
      .clk_i (clk),
      .rst_ni(rst_n),
      .btn_i (btn_lr),
      .rise_o(lr_ev)
   );

   ctrl_state_t     state_q, state_d;
   ctrl_state_t     exp_q, exp_d;
   logic [TmoW-1:0] tmo_q, tmo_d;
   logic            pend_q, pend_d;
   logic            start_q, start_d;
   logic            stop_q, stop_d;
   logic            rst_cmd_q, rst_cmd_d;
   logic            err_q, err_d;
   logic            ovf_q, ovf_d;
   logic            lap_push, flush;

   lap_t            mem_q [LAP_DEPTH];
   logic [PtrW-1:0] wptr_q, wptr_d;
   logic [PtrW-1:0] rptr_q, rptr_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            pop, full, push_ok;
   lap_t            lap_in, head;

   // A command cycle (pend_q) sits between the pulse and WAIT_ACK; events there are dropped.
   always_comb begin
      state_d   = state_q;
      exp_d     = exp_q;
      tmo_d     = tmo_q;
      pend_d    = 1'b0;
      start_d   = 1'b0;
      stop_d    = 1'b0;
      rst_cmd_d = 1'b0;
      err_d     = err_q;
      lap_push  = 1'b0;
      flush     = 1'b0;
      if (pend_q) begin
         state_d = StWaitAck;
         tmo_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (ss_ev) begin
                  start_d = 1'b1;
                  exp_d   = StRunning;
                  pend_d  = 1'b1;
               end
            end
            StRunning: begin
               if (ss_ev) begin
                  stop_d = 1'b1;
                  exp_d  = StPaused;
                  pend_d = 1'b1;
               end else if (lr_ev) begin
                  lap_push = 1'b1;
               end
            end
            StPaused: begin
               if (ss_ev) begin
                  start_d = 1'b1;
                  exp_d   = StRunning;
                  pend_d  = 1'b1;
               end else if (lr_ev) begin
                  rst_cmd_d = 1'b1;
                  flush     = 1'b1;
                  exp_d     = StIdle;
                  pend_d    = 1'b1;
               end
            end
            StWaitAck: begin
               if (sw_status == exp_q) begin
                  state_d = exp_q;
               end else if (tmo_q == TmoW'(ACK_TIMEOUT - 1)) begin
                  err_d   = 1'b1;
                  state_d = status_to_state(sw_status);
               end else begin
                  tmo_d = tmo_q + 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   assign lap_in  = '{minutes: sw_minutes, seconds: sw_seconds};
   assign head    = mem_q[rptr_q];
   assign full    = (cnt_q == CntW'(LAP_DEPTH));
   assign pop     = (cnt_q != '0) && lap_ready;
   assign push_ok = lap_push && (!full || pop);

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      ovf_d  = ovf_q;
      if (flush) begin
         wptr_d = '0;
         rptr_d = '0;
         cnt_d  = '0;
         ovf_d  = 1'b0;
      end else begin
         if (lap_push && !push_ok) ovf_d = 1'b1;
         if (push_ok) wptr_d = wptr_q + 1'b1;
         if (pop) rptr_d = rptr_q + 1'b1;
         cnt_d = cnt_q + CntW'(push_ok) - CntW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         exp_q     <= StIdle;
         tmo_q     <= '0;
         pend_q    <= 1'b0;
         start_q   <= 1'b0;
         stop_q    <= 1'b0;
         rst_cmd_q <= 1'b0;
         err_q     <= 1'b0;
         ovf_q     <= 1'b0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         cnt_q     <= '0;
         for (int i = 0; i < int'(LAP_DEPTH); i++) mem_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         exp_q     <= exp_d;
         tmo_q     <= tmo_d;
         pend_q    <= pend_d;
         start_q   <= start_d;
         stop_q    <= stop_d;
         rst_cmd_q <= rst_cmd_d;
         err_q     <= err_d;
         ovf_q     <= ovf_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         cnt_q     <= cnt_d;
         if (push_ok) mem_q[wptr_q] <= lap_in;
      end
   end

   assign sw_start     = start_q;
   assign sw_stop      = stop_q;
   assign sw_reset     = rst_cmd_q;
   assign lap_valid    = (cnt_q != '0);
   assign lap_minutes  = head.minutes;
   assign lap_seconds  = head.seconds;
   assign lap_count    = cnt_q;
   assign lap_overflow = ovf_q;
   assign ctrl_err     = err_q;
   assign ctrl_state   = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: acknowledging stopwatch model, lap scoreboard,
// pulse monitor, and directed button scenarios.
module tb_stopwatch_ctrl;
   import stopwatch_pkg::*;

   localparam int unsigned DB    = 4;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned TMO   = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_ss = 1'b0, btn_lr = 1'b0;
   logic [7:0] sw_minutes = '0;
   logic [5:0] sw_seconds = '0;
   logic [1:0] sw_status;
   logic       sw_start, sw_stop, sw_reset;
   logic       lap_valid, lap_ready = 1'b0;
   logic [7:0] lap_minutes;
   logic [5:0] lap_seconds;
   logic [2:0] lap_count;
   logic       lap_overflow, ctrl_err;
   logic [1:0] ctrl_state;

   always #5 clk = ~clk;

   stopwatch_ctrl #(
      .DEBOUNCE_CYCLES(DB),
      .LAP_DEPTH      (DEPTH),
      .ACK_TIMEOUT    (TMO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_ss      (btn_ss),
      .btn_lr      (btn_lr),
      .sw_minutes  (sw_minutes),
      .sw_seconds  (sw_seconds),
      .sw_status   (sw_status),
      .sw_start    (sw_start),
      .sw_stop     (sw_stop),
      .sw_reset    (sw_reset),
      .lap_valid   (lap_valid),
      .lap_ready   (lap_ready),
      .lap_minutes (lap_minutes),
      .lap_seconds (lap_seconds),
      .lap_count   (lap_count),
      .lap_overflow(lap_overflow),
      .ctrl_err    (ctrl_err),
      .ctrl_state  (ctrl_state)
   );

   int   n_cmp = 0, n_err = 0;
   int   n_start = 0, n_stop = 0, n_reset = 0, n_wide = 0;
   logic ack_en = 1'b1;
   lap_t lap_sb[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Stopwatch model: status follows a command two edges after the pulse.
   initial begin
      int         ack_cnt;
      logic [1:0] ack_val;
      ack_cnt   = 0;
      ack_val   = SW_IDLE;
      sw_status = SW_IDLE;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            ack_cnt   = 0;
            sw_status = SW_IDLE;
         end else begin
            if (ack_cnt > 0) begin
               ack_cnt--;
               if (ack_cnt == 0) sw_status = ack_val;
            end
            if (ack_en) begin
               if (sw_start) begin
                  ack_cnt = 1; ack_val = SW_RUNNING;
               end else if (sw_stop) begin
                  ack_cnt = 1; ack_val = SW_PAUSED;
               end else if (sw_reset) begin
                  ack_cnt = 1; ack_val = SW_IDLE;
               end
            end
         end
      end
   end

   // Pulse counter and lap consumer.
   initial begin
      logic p_start, p_stop, p_rst;
      lap_t e;
      p_start = 1'b0; p_stop = 1'b0; p_rst = 1'b0;
      forever begin
         @(negedge clk);
         if (sw_start) n_start++;
         if (sw_stop) n_stop++;
         if (sw_reset) n_reset++;
         if ((sw_start && p_start) || (sw_stop && p_stop) || (sw_reset && p_rst)) n_wide++;
         p_start = sw_start; p_stop = sw_stop; p_rst = sw_reset;
         if (lap_valid && lap_ready) begin
            if (lap_sb.size() == 0) begin
               check("lap_unexpected", 32'd1, 32'd0);
            end else begin
               e = lap_sb.pop_front();
               check("lap_pop_data", {lap_minutes, lap_seconds}, e);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic press_ss();
      btn_ss = 1'b1;
      tick(8);
      btn_ss = 1'b0;
      tick(DB + 4);
   endtask

   task automatic press_lr(input bit expect_lap);
      if (expect_lap && lap_sb.size() < DEPTH) lap_sb.push_back({sw_minutes, sw_seconds});
      btn_lr = 1'b1;
      tick(6);
      btn_lr = 1'b0;
      tick(DB + 4);
   endtask

   task automatic wait_state(input logic [1:0] target, input int budget, input string tag);
      for (int i = 0; i < budget && ctrl_state != target; i++) tick(1);
      check(tag, ctrl_state, target);
   endtask

   task automatic wait_pulse(input bit is_stop);
      int i;
      for (i = 0; i < 30 && !(is_stop ? sw_stop : sw_start); i++) tick(1);
      check(is_stop ? "stop_pulse_seen" : "start_pulse_seen", (is_stop ? sw_stop : sw_start), 1);
   endtask

   initial begin
      int s0, s1, s2, n3;

      // Reset values
      tick(3);
      check("rst_state", ctrl_state, StIdle);
      check("rst_count", lap_count, 0);
      check("rst_flags", {lap_valid, lap_overflow, ctrl_err, sw_start, sw_stop, sw_reset}, 0);
      check("rst_lap_data", {lap_minutes, lap_seconds}, 0);
      rst_n = 1'b1;
      tick(2);

      // Start: exact button latency and state sequence
      btn_ss = 1'b1;
      repeat (DB + 2) @(posedge clk);
      #1 check("start_early", sw_start, 0);
      @(posedge clk);
      #1 check("start_latency", sw_start, 1);
      @(posedge clk);
      #1 check("start_width", sw_start, 0);
      check("state_wait_ack", ctrl_state, StWaitAck);
      tick(3);
      btn_ss = 1'b0;
      wait_state(StRunning, 20, "state_running");
      check("start_no_err", ctrl_err, 0);
      tick(DB + 4);
      check("start_pulse_count", n_start, 1);

      // Debounce: 3-on/1-off glitching must not register
      sw_minutes = 8'd2;
      sw_seconds = 6'd17;
      for (int i = 0; i < 5; i++) begin
         btn_lr = 1'b1;
         tick(3);
         btn_lr = 1'b0;
         tick(1);
      end
      tick(DB + 4);
      check("glitch_no_lap", lap_count, 0);
      press_lr(1'b1);
      check("lap1_count", lap_count, 1);
      check("lap1_valid", lap_valid, 1);
      check("lap1_head", {lap_minutes, lap_seconds}, {8'd2, 6'd17});

      // Fill past capacity with the consumer stalled
      for (int i = 0; i < 4; i++) begin
         sw_minutes = 8'(3 + i);
         sw_seconds = 6'(10 * i + 5);
         press_lr(1'b1);
      end
      check("full_count", lap_count, DEPTH);
      check("full_overflow", lap_overflow, 1);
      check("full_head_stable", {lap_minutes, lap_seconds}, {8'd2, 6'd17});
      lap_ready = 1'b1;
      tick(8);
      lap_ready = 1'b0;
      check("drain_valid", lap_valid, 0);
      check("drain_count", lap_count, 0);
      check("drain_sb_empty", lap_sb.size(), 0);

      // Pause, then reset flushes laps and overflow
      sw_minutes = 8'd9;
      sw_seconds = 6'd59;
      press_lr(1'b1);
      check("pre_reset_count", lap_count, 1);
      press_ss();
      wait_state(StPaused, 30, "state_paused");
      check("stop_pulse_count", n_stop, 1);
      press_lr(1'b0);
      lap_sb.delete();
      wait_state(StIdle, 30, "state_idle_after_reset");
      check("reset_pulse_count", n_reset, 1);
      check("flush_count", lap_count, 0);
      check("flush_valid", lap_valid, 0);
      check("flush_overflow", lap_overflow, 0);

      // Timeout: no acknowledge; presses during WAIT_ACK are discarded
      ack_en = 1'b0;
      s0 = n_start; s1 = n_stop; s2 = n_reset;
      btn_ss = 1'b1;
      wait_pulse(1'b0);
      btn_ss = 1'b0;
      n3 = 0;
      fork
         begin
            tick(1);
            for (int i = 0; i < 40 && ctrl_state == StWaitAck; i++) begin
               n3++;
               tick(1);
            end
         end
         begin
            tick(6);
            btn_ss = 1'b1;
            btn_lr = 1'b1;
            tick(8);
            btn_ss = 1'b0;
            btn_lr = 1'b0;
         end
      join
      check("tmo_wait_cycles", n3, TMO);
      check("tmo_err", ctrl_err, 1);
      check("tmo_state_follows_status", ctrl_state, StIdle);
      tick(DB + 6);
      check("tmo_start_pulses", n_start - s0, 1);
      check("tmo_other_pulses", (n_stop - s1) + (n_reset - s2), 0);

      // Reset in WAIT_ACK with laps queued
      ack_en = 1'b1;
      press_ss();
      wait_state(StRunning, 30, "state_running_2");
      for (int i = 0; i < 3; i++) begin
         sw_minutes = 8'(20 + i);
         sw_seconds = 6'(40 + i);
         press_lr(1'b1);
      end
      check("midop_count", lap_count, 3);
      ack_en = 1'b0;
      btn_ss = 1'b1;
      wait_pulse(1'b1);
      btn_ss = 1'b0;
      tick(1);
      check("midop_wait_ack", ctrl_state, StWaitAck);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("midop_rst_state", ctrl_state, StIdle);
      check("midop_rst_count", lap_count, 0);
      check("midop_rst_flags", {lap_valid, lap_overflow, ctrl_err, sw_start, sw_stop, sw_reset}, 0);
      check("midop_rst_lap_data", {lap_minutes, lap_seconds}, 0);
      lap_sb.delete();
      s0 = n_start; s1 = n_stop; s2 = n_reset;
      tick(3);
      rst_n = 1'b1;
      ack_en = 1'b1;
      tick(20);
      check("post_rst_no_pulse", (n_start - s0) + (n_stop - s1) + (n_reset - s2), 0);
      check("post_rst_state", ctrl_state, StIdle);
      check("pulse_width_one", n_wide, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Front-panel controller for `stopwatch_top`: turns two raw push-buttons into one-cycle `start`/`stop`/`reset` command pulses and waits for the stopwatch to acknowledge each one through its `status`. While running, it records lap times into a small FIFO that downstream logic drains with a valid/ready handshake. It sits between the board buttons and `stopwatch_top`, sharing that block's clock.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable cycles before a debounced level changes.
- `LAP_DEPTH`, 4: lap FIFO entries (power of 2, ≥2).
- `ACK_TIMEOUT`, 16: cycles to wait for `sw_status` to match a command.
- `clk  in  1`: single clock for the block.
- `rst_n  in  1`: reset. Synchronous, active-low.
- `btn_ss  in  1`: raw start/stop button, asynchronous.
- `btn_lr  in  1`: raw lap/reset button, asynchronous.
- `sw_minutes  in  8`: stopwatch minutes.
- `sw_seconds  in  6`: stopwatch seconds.
- `sw_status  in  2`: stopwatch status. 00 IDLE, 01 RUNNING, 10 PAUSED.
- `sw_start  out  1`, `sw_stop  out  1`, `sw_reset  out  1`: one-cycle command pulses to `stopwatch_top`.
- `lap_valid  out  1`: FIFO head is valid.
- `lap_ready  in  1`: consumer accepts the head.
- `lap_minutes  out  8`, `lap_seconds  out  6`: FIFO head data.
- `lap_count  out  $clog2(LAP_DEPTH+1)`: number of entries held.
- `lap_overflow  out  1`: sticky; set when a lap is dropped.
- `ctrl_err  out  1`: sticky; set on an acknowledge timeout.
- `ctrl_state  out  2`: current controller state.

## Operation
- Each button path is a 2-flop synchroniser followed by a debouncer.
  - The debounced level flips once the synchronised input has differed from it for `DEBOUNCE_CYCLES` consecutive cycles. A glitch restarts the count.
  - A rising edge on the debounced level produces one event.
- The FSM has four states: IDLE(0), RUNNING(1), PAUSED(2), WAIT_ACK(3). WAIT_ACK holds `exp_state` and a timeout counter.
- `btn_ss` event:
  - IDLE: pulse `sw_start`, expect RUNNING.
  - RUNNING: pulse `sw_stop`, expect PAUSED.
  - PAUSED: pulse `sw_start`, expect RUNNING.
- `btn_lr` event:
  - RUNNING: capture a lap and stay in RUNNING.
  - PAUSED: pulse `sw_reset`, flush the FIFO, clear `lap_overflow`, expect IDLE.
  - IDLE: ignored.
- WAIT_ACK:
  - Leave for `exp_state` on the first cycle where `sw_status == exp_state`.
  - If `ACK_TIMEOUT` cycles pass without a match, set `ctrl_err` and go to the state that `sw_status` encodes. The encoding 11 maps to IDLE.
  - All button events arriving in WAIT_ACK are discarded; they are not queued.
- If both events occur in the same cycle, `btn_ss` wins and the `btn_lr` event is dropped.
- Lap capture:
  - Writes `{sw_minutes, sw_seconds}` as sampled in the event cycle.
  - If the FIFO is full and there is no simultaneous pop, the lap is dropped and `lap_overflow` is set.
  - If the FIFO is full and a pop happens the same cycle, the write succeeds.
- Pop: occurs when `lap_valid && lap_ready`. Push and pop in the same cycle leave `lap_count` unchanged.
- Reset values: all outputs 0, state IDLE, FIFO empty, debounced levels 0.
  - `rst_n` low at any point, including WAIT_ACK or mid-debounce, clears everything on the next edge.
  - No command pulse is emitted while `rst_n` is low.

## Timing
- Button latency: if raw goes high before edge N and stays high, the command pulse or lap write happens at edge N+`DEBOUNCE_CYCLES`+2. The pulse is high for exactly one cycle.
- State update:
  - `ctrl_state` shows WAIT_ACK in the cycle after the pulse.
  - The earliest exit from WAIT_ACK is the cycle after that.
- Lap data and count:
  - Lap data appears on `lap_*`, with `lap_valid` high, one cycle after the write edge.
  - `lap_count` updates on that same edge.
- The FIFO head is registered and stays stable while `lap_valid && !lap_ready`.

## Structure
- `stopwatch_pkg` holds:
  - the `sw_status` encoding constants (shared with `stopwatch_top`);
  - the `ctrl_state_t` enum;
  - the `lap_t` struct {8-bit minutes, 6-bit seconds}.
- Sub-module `btn_debounce` (synchroniser, debounce counter, rising-edge pulse) is instantiated twice.
- The FIFO stays inline as a circular buffer with read and write pointers plus a count.

## Test plan
- Start: hold `btn_ss` for 10 cycles, model acks 2 cycles after the pulse → one `sw_start` pulse, `ctrl_state` goes 0→3→1, `ctrl_err`=0.
- Debounce: toggle `btn_lr` in a 3-on/1-off pattern while RUNNING → no lap written. A clean 6-cycle press → one lap with the current min:sec (e.g. 02:17) and `lap_count`=1.
- FIFO full and drain: 5 laps with `lap_ready`=0 → `lap_count`=4, `lap_overflow`=1. Then `lap_ready`=1 → the 4 entries come out in order, then `lap_valid`=0.
- Pause and reset: from RUNNING, press `btn_ss` → `sw_stop`, state PAUSED. Press `btn_lr` → `sw_reset`, FIFO flushed, overflow cleared, state IDLE.
- Timeout: model never acks `sw_start` → after 16 cycles `ctrl_err`=1 and state follows `sw_status`=00 (IDLE). Presses made during WAIT_ACK produce no pulses.
- Reset mid-op: drive `rst_n`=0 while in WAIT_ACK with 3 laps queued → next edge gives all outputs 0 and `lap_count`=0; no stray pulse after release.
